// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter: shares one SPI byte engine between a host port (H) and an
// autonomous loader port (A). Each byte is arbitrated, started, tracked
// through the engine's busy window and acknowledged to its owner. The arbiter
// drives chip-select and supports a per-owner lock so multi-byte commands stay
// contiguous on the bus.
module spi_xfer_arbiter #(
  parameter int START_TIMEOUT = 64,
  parameter int CNT_W         = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       h_req,
  input  logic [7:0] h_txdata,
  input  logic       h_hold,
  output logic       h_ack,
  output logic       h_err,
  output logic [7:0] h_rxdata,
  input  logic       a_req,
  input  logic [7:0] a_txdata,
  input  logic       a_hold,
  output logic       a_ack,
  output logic       a_err,
  output logic [7:0] a_rxdata,
  output logic [7:0] eng_txdata,
  output logic       eng_txstart,
  input  logic [7:0] eng_rxdata,
  input  logic       eng_busy,
  output logic       spi_ssel_n,
  output logic       owner
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_DONE      = 3'd4
  } state_e;

  localparam logic PORT_H = 1'b0;
  localparam logic PORT_A = 1'b1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  state_e           state_q, state_d;
  logic             lock_q, lock_d;
  logic             last_q, last_d;
  logic             owner_q, owner_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       eng_txdata_q, eng_txdata_d;
  logic             eng_txstart_q, eng_txstart_d;
  logic             h_ack_q, h_ack_d, h_err_q, h_err_d;
  logic             a_ack_q, a_ack_d, a_err_q, a_err_d;
  logic [7:0]       h_rxdata_q, h_rxdata_d;
  logic [7:0]       a_rxdata_q, a_rxdata_d;
  logic             ssel_n_q, ssel_n_d;

  logic             own_req_s;
  logic             own_hold_s;
  logic             grant_s;
  logic             grant_port_s;

  // Arbitration: engine guard, lock restriction, then round-robin on ties.
  always_comb begin
    own_req_s    = (owner_q == PORT_A) ? a_req  : h_req;
    own_hold_s   = (owner_q == PORT_A) ? a_hold : h_hold;
    grant_s      = 1'b0;
    grant_port_s = PORT_H;
    if (eng_busy) begin
      // Engine still running (e.g. after an arbiter-only reset): start nothing.
      grant_s      = 1'b0;
      grant_port_s = PORT_H;
    end else if (lock_q) begin
      grant_s      = own_req_s;
      grant_port_s = owner_q;
    end else if (h_req && a_req) begin
      grant_s      = 1'b1;
      grant_port_s = ~last_q;
    end else if (h_req) begin
      grant_s      = 1'b1;
      grant_port_s = PORT_H;
    end else if (a_req) begin
      grant_s      = 1'b1;
      grant_port_s = PORT_A;
    end else begin
      grant_s      = 1'b0;
      grant_port_s = PORT_H;
    end
  end

  // Next-state logic for the byte sequencer and its bookkeeping registers.
  always_comb begin
    state_d      = state_q;
    lock_d       = lock_q;
    last_d       = last_q;
    owner_d      = owner_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    eng_txdata_d = eng_txdata_q;
    case (state_q)
      S_IDLE: begin
        // Lock is released once the owner has neither a request nor a hold.
        if (lock_q && !own_req_s && !own_hold_s) begin
          lock_d = 1'b0;
        end else begin
          lock_d = lock_q;
        end
        if (grant_s) begin
          state_d      = S_START;
          owner_d      = grant_port_s;
          last_d       = grant_port_s;
          eng_txdata_d = (grant_port_s == PORT_A) ? a_txdata : h_txdata;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        cnt_d   = CNT_ZERO;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (eng_busy) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_WAIT_DONE: begin
        // No timeout here: a slow-mode byte legitimately takes hundreds of clocks.
        if (eng_busy) begin
          state_d = S_WAIT_DONE;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        lock_d  = own_hold_s;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode: every output is registered from next-state values so the
  // pulses and chip-select line up with the state they belong to.
  always_comb begin
    eng_txstart_d = (state_d == S_START);
    h_ack_d       = (state_d == S_DONE) && (owner_d == PORT_H);
    a_ack_d       = (state_d == S_DONE) && (owner_d == PORT_A);
    h_err_d       = h_ack_d && err_d;
    a_err_d       = a_ack_d && err_d;
    ssel_n_d      = !((state_d != S_IDLE) || lock_d);
    if ((state_q == S_DONE) && (owner_q == PORT_H) && !err_q) begin
      h_rxdata_d = eng_rxdata;
    end else begin
      h_rxdata_d = h_rxdata_q;
    end
    if ((state_q == S_DONE) && (owner_q == PORT_A) && !err_q) begin
      a_rxdata_d = eng_rxdata;
    end else begin
      a_rxdata_d = a_rxdata_q;
    end
  end

  // Sequencer state register; last owner resets to A so H wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      lock_q       <= 1'b0;
      last_q       <= PORT_A;
      owner_q      <= PORT_H;
      err_q        <= 1'b0;
      cnt_q        <= CNT_ZERO;
      eng_txdata_q <= 8'h00;
    end else begin
      state_q      <= state_d;
      lock_q       <= lock_d;
      last_q       <= last_d;
      owner_q      <= owner_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      eng_txdata_q <= eng_txdata_d;
    end
  end

  // Registered output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_txstart_q <= 1'b0;
      h_ack_q       <= 1'b0;
      h_err_q       <= 1'b0;
      a_ack_q       <= 1'b0;
      a_err_q       <= 1'b0;
      h_rxdata_q    <= 8'h00;
      a_rxdata_q    <= 8'h00;
      ssel_n_q      <= 1'b1;
    end else begin
      eng_txstart_q <= eng_txstart_d;
      h_ack_q       <= h_ack_d;
      h_err_q       <= h_err_d;
      a_ack_q       <= a_ack_d;
      a_err_q       <= a_err_d;
      h_rxdata_q    <= h_rxdata_d;
      a_rxdata_q    <= a_rxdata_d;
      ssel_n_q      <= ssel_n_d;
    end
  end

  assign eng_txdata  = eng_txdata_q;
  assign eng_txstart = eng_txstart_q;
  assign h_ack       = h_ack_q;
  assign h_err       = h_err_q;
  assign h_rxdata    = h_rxdata_q;
  assign a_ack       = a_ack_q;
  assign a_err       = a_err_q;
  assign a_rxdata    = a_rxdata_q;
  assign spi_ssel_n  = ssel_n_q;
  assign owner       = owner_q;

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Self-checking bench for spi_xfer_arbiter: a behavioural SPI engine model,
// one requester process per port, an output monitor and a scoreboard of
// expected byte completions.
`timescale 1ns/1ps
module tb_spi_xfer_arbiter;
  localparam int START_TIMEOUT = 64;
  localparam int CNT_W         = 7;

  typedef struct packed {
    logic       port;
    logic       err;
    logic [7:0] tx;
    logic [7:0] rx;
  } ev_t;

  typedef struct packed {
    logic [7:0] tx;
    logic       hold;
  } item_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       h_req = 1'b0, h_hold = 1'b0;
  logic [7:0] h_txdata = 8'h00;
  logic       h_ack, h_err;
  logic [7:0] h_rxdata;
  logic       a_req = 1'b0, a_hold = 1'b0;
  logic [7:0] a_txdata = 8'h00;
  logic       a_ack, a_err;
  logic [7:0] a_rxdata;
  logic [7:0] eng_txdata;
  logic       eng_txstart;
  logic [7:0] eng_rxdata = 8'h00;
  logic       eng_busy = 1'b0;
  logic       spi_ssel_n, owner;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  spi_xfer_arbiter #(.START_TIMEOUT(START_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .h_req(h_req), .h_txdata(h_txdata), .h_hold(h_hold),
    .h_ack(h_ack), .h_err(h_err), .h_rxdata(h_rxdata),
    .a_req(a_req), .a_txdata(a_txdata), .a_hold(a_hold),
    .a_ack(a_ack), .a_err(a_err), .a_rxdata(a_rxdata),
    .eng_txdata(eng_txdata), .eng_txstart(eng_txstart),
    .eng_rxdata(eng_rxdata), .eng_busy(eng_busy),
    .spi_ssel_n(spi_ssel_n), .owner(owner)
  );

  // ---------------- engine model: reply = sent byte ^ 0x99 ----------------
  int         eng_delay = 1;
  int         eng_len = 9;
  logic       eng_enable = 1'b1;
  int         eng_phase = 0;
  int         eng_wait = 0;
  int         eng_left = 0;
  logic [7:0] eng_seen = 8'h00;

  always @(negedge clk) begin
    if (eng_phase == 0 && eng_txstart && eng_enable) begin
      eng_phase = 1;
      eng_wait  = eng_delay;
      eng_seen  = eng_txdata;
    end
    if (eng_phase == 1) begin
      if (eng_wait == 0) begin
        eng_busy  = 1'b1;
        eng_left  = eng_len;
        eng_phase = 2;
      end else begin
        eng_wait = eng_wait - 1;
      end
    end else if (eng_phase == 2) begin
      eng_left = eng_left - 1;
      if (eng_left == 0) begin
        eng_busy   = 1'b0;
        eng_rxdata = eng_seen ^ 8'h99;
        eng_phase  = 0;
      end
    end
  end

  // ---------------- requesters: hold req until ack, then next item ---------
  item_t h_items[$];
  item_t a_items[$];
  item_t h_dummy, a_dummy;
  logic  h_ack_seen = 1'b0, a_ack_seen = 1'b0;

  always begin
    @(negedge clk);
    h_ack_seen = h_ack;
    @(posedge clk);
    #1;
    if (h_ack_seen && h_items.size() > 0) h_dummy = h_items.pop_front();
    if (h_items.size() > 0) begin
      h_req    = 1'b1;
      h_txdata = h_items[0].tx;
      h_hold   = h_items[0].hold;
    end else begin
      h_req  = 1'b0;
      h_hold = 1'b0;
    end
  end

  always begin
    @(negedge clk);
    a_ack_seen = a_ack;
    @(posedge clk);
    #1;
    if (a_ack_seen && a_items.size() > 0) a_dummy = a_items.pop_front();
    if (a_items.size() > 0) begin
      a_req    = 1'b1;
      a_txdata = a_items[0].tx;
      a_hold   = a_items[0].hold;
    end else begin
      a_req  = 1'b0;
      a_hold = 1'b0;
    end
  end

  // ---------------- monitor ----------------
  int   cyc = 0, t_start = 0, t_req = 0, n_txstart = 0;
  int   n_ack_h = 0, n_ack_a = 0, last_dt = 0, hi_run = 0;
  logic h_req_prev = 1'b0;
  logic pend = 1'b0;
  ev_t  pend_ev;
  ev_t  obs_q[$];
  ev_t  exp_q[$];
  int   hi_q[$];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (pend) begin
      pend_ev.rx = pend_ev.port ? a_rxdata : h_rxdata;
      obs_q.push_back(pend_ev);
      pend = 1'b0;
    end
    if (h_req && !h_req_prev) t_req = cyc;
    h_req_prev = h_req;
    if (eng_txstart) begin
      n_txstart = n_txstart + 1;
      t_start   = cyc;
      hi_q.push_back(hi_run);
      hi_run = 0;
    end else if (spi_ssel_n) begin
      hi_run = hi_run + 1;
    end
    if (h_ack || a_ack) begin
      pend        = 1'b1;
      pend_ev.port = a_ack;
      pend_ev.err  = a_ack ? a_err : h_err;
      pend_ev.tx   = eng_txdata;
      pend_ev.rx   = 8'h00;
      last_dt      = cyc - t_start;
      if (h_ack) n_ack_h = n_ack_h + 1;
      if (a_ack) n_ack_a = n_ack_a + 1;
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [7:0] mdl_rx_h = 8'h00, mdl_rx_a = 8'h00;

  task automatic push_byte(input logic port, input logic [7:0] tx,
                           input logic hold, input logic err);
    item_t it;
    ev_t   e;
    it.tx   = tx;
    it.hold = hold;
    if (port) begin
      a_items.push_back(it);
      if (!err) mdl_rx_a = tx ^ 8'h99;
      e.rx = mdl_rx_a;
    end else begin
      h_items.push_back(it);
      if (!err) mdl_rx_h = tx ^ 8'h99;
      e.rx = mdl_rx_h;
    end
    e.port = port;
    e.err  = err;
    e.tx   = tx;
    exp_q.push_back(e);
  endtask

  task automatic wait_obs(input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while (obs_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    ok = (obs_q.size() >= n);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    mdl_rx_h = 8'h00;
    mdl_rx_a = 8'h00;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({h_ack, h_err, a_ack, a_err, eng_txstart, owner} !== 6'b000000) begin
      n_fail++;
      $display("FAIL reset_pulses: got %b want 000000", {h_ack, h_err, a_ack, a_err, eng_txstart, owner});
    end
    n_checks++;
    if ({h_rxdata, a_rxdata, eng_txdata} !== 24'h000000) begin
      n_fail++;
      $display("FAIL reset_data: got %h want 000000", {h_rxdata, a_rxdata, eng_txdata});
    end
    n_checks++;
    if (spi_ssel_n !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ssel: got %b want 1", spi_ssel_n);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (spi_ssel_n !== 1'b1 || n_txstart !== 0) begin
      n_fail++;
      $display("FAIL idle_after_reset: ssel=%b txstarts=%0d want 1 and 0", spi_ssel_n, n_txstart);
    end
  endtask

  task automatic test_single_byte();
    int  base_s, base_h, base_a;
    bit  ok;
    ev_t e, o;
    base_s = n_txstart; base_h = n_ack_h; base_a = n_ack_a;
    eng_delay = 1; eng_len = 9;
    push_byte(1'b0, 8'hA5, 1'b0, 1'b0);
    wait_obs(1, 200, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL single_timeout: got %0d acks want 1", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL single_ev: got {port,err,tx,rx}=%h want %h", o, e); end
    end
    n_checks++;
    if (n_txstart - base_s !== 1) begin n_fail++; $display("FAIL single_txstarts: got %0d want 1", n_txstart - base_s); end
    n_checks++;
    if (t_start - t_req !== 1) begin n_fail++; $display("FAIL single_start_lat: got %0d want 1", t_start - t_req); end
    n_checks++;
    if (last_dt !== eng_delay + eng_len + 1) begin n_fail++; $display("FAIL single_ack_lat: got %0d want %0d", last_dt, eng_delay + eng_len + 1); end
    n_checks++;
    if (n_ack_h - base_h !== 1 || n_ack_a !== base_a) begin
      n_fail++; $display("FAIL single_ack_count: got h=%0d a=%0d want 1 0", n_ack_h - base_h, n_ack_a - base_a);
    end
    n_checks++;
    if (h_rxdata !== 8'h3C || spi_ssel_n !== 1'b1) begin
      n_fail++; $display("FAIL single_rx_ssel: got rx=%h ssel=%b want 3c 1", h_rxdata, spi_ssel_n);
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_round_robin();
    bit  ok;
    ev_t e, o;
    int  i;
    do_reset();
    push_byte(1'b0, 8'h11, 1'b0, 1'b0);
    push_byte(1'b1, 8'h22, 1'b0, 1'b0);
    push_byte(1'b0, 8'h33, 1'b0, 1'b0);
    push_byte(1'b1, 8'h44, 1'b0, 1'b0);
    wait_obs(4, 400, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rr_timeout: got %0d acks want 4", obs_q.size()); end
    i = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL rr_ev[%0d]: got {port,err,tx,rx}=%h want %h", i, o, e); end
      i++;
    end
    n_checks++;
    if (owner !== 1'b1) begin n_fail++; $display("FAIL rr_owner: got %b want 1", owner); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_lock();
    bit  ok;
    ev_t e, o;
    int  i, hb;
    hb = hi_q.size();
    push_byte(1'b0, 8'h03, 1'b1, 1'b0);
    push_byte(1'b0, 8'h04, 1'b1, 1'b0);
    push_byte(1'b0, 8'h05, 1'b0, 1'b0);
    push_byte(1'b1, 8'h66, 1'b0, 1'b0);
    wait_obs(4, 400, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL lock_timeout: got %0d acks want 4", obs_q.size()); end
    i = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL lock_ev[%0d]: got {port,err,tx,rx}=%h want %h", i, o, e); end
      i++;
    end
    n_checks++;
    if (hi_q.size() - hb !== 4) begin
      n_fail++; $display("FAIL lock_starts: got %0d want 4", hi_q.size() - hb);
    end else begin
      n_checks++;
      if (hi_q[hb+1] !== 0 || hi_q[hb+2] !== 0) begin
        n_fail++; $display("FAIL lock_ssel_held: got high cycles %0d,%0d want 0,0", hi_q[hb+1], hi_q[hb+2]);
      end
      n_checks++;
      if (hi_q[hb+3] < 1) begin
        n_fail++; $display("FAIL lock_ssel_gap: got %0d high cycles want >=1", hi_q[hb+3]);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_timeout();
    bit  ok;
    ev_t e, o;
    eng_enable = 1'b0;
    push_byte(1'b0, 8'h77, 1'b0, 1'b1);
    wait_obs(1, 300, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL to_wait: got %0d acks want 1", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL to_ev: got {port,err,tx,rx}=%h want %h", o, e); end
    end
    n_checks++;
    if (last_dt !== START_TIMEOUT + 1) begin
      n_fail++; $display("FAIL to_latency: got %0d want %0d", last_dt, START_TIMEOUT + 1);
    end
    n_checks++;
    if (h_rxdata !== 8'h9C) begin n_fail++; $display("FAIL to_rx_kept: got %h want 9c", h_rxdata); end
    eng_enable = 1'b1;
    push_byte(1'b1, 8'h5A, 1'b0, 1'b0);
    wait_obs(1, 200, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL to_next_wait: got %0d acks want 1", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL to_next_ev: got {port,err,tx,rx}=%h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid();
    bit  ok;
    ev_t e, o;
    int  k, base_s, base_h;
    eng_delay = 1; eng_len = 40;
    push_byte(1'b0, 8'h12, 1'b0, 1'b0);
    k = 0;
    while (!eng_busy && k < 50) begin @(negedge clk); #1; k++; end
    n_checks++;
    if (eng_busy !== 1'b1) begin n_fail++; $display("FAIL rm_busy_rise: got %b want 1", eng_busy); end
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (spi_ssel_n !== 1'b1 || eng_txstart !== 1'b0 || h_ack !== 1'b0) begin
      n_fail++; $display("FAIL rm_async: got ssel=%b txstart=%b ack=%b want 1 0 0", spi_ssel_n, eng_txstart, h_ack);
    end
    repeat (2) @(negedge clk);
    base_s = n_txstart; base_h = n_ack_h;
    rst_n = 1'b1; mdl_rx_h = 8'h00; mdl_rx_a = 8'h00;
    k = 0;
    while (eng_busy && k < 100) begin @(negedge clk); #1; k++; end
    n_checks++;
    if (eng_busy !== 1'b0 || n_txstart !== base_s) begin
      n_fail++; $display("FAIL rm_no_grant_busy: got busy=%b starts=%0d want 0 %0d", eng_busy, n_txstart, base_s);
    end
    n_checks++;
    if (n_ack_h !== base_h || obs_q.size() !== 0 || pend !== 1'b0) begin
      n_fail++; $display("FAIL rm_no_ack: got %0d acks want 0", n_ack_h - base_h + obs_q.size());
    end
    wait_obs(1, 200, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rm_retry_wait: got %0d acks want 1", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL rm_ev: got {port,err,tx,rx}=%h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_slow_engine();
    bit  ok;
    ev_t e, o;
    int  base_s;
    eng_delay = 33; eng_len = 5;
    base_s = n_txstart;
    push_byte(1'b1, 8'hC3, 1'b0, 1'b0);
    wait_obs(1, 300, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL slow_wait: got %0d acks want 1", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL slow_ev: got {port,err,tx,rx}=%h want %h", o, e); end
    end
    n_checks++;
    if (last_dt !== 39 || n_txstart - base_s !== 1) begin
      n_fail++; $display("FAIL slow_timing: got dt=%0d starts=%0d want 39 1", last_dt, n_txstart - base_s);
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_round_robin();
    test_lock();
    test_timeout();
    test_reset_mid();
    test_slow_engine();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
